// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer:
// opcodes, instruction fields, FSM states and flag bit indices.
package exec_sequencer_pkg;

   localparam int OPC_MSB  = 11;
   localparam int OPC_LSB  = 8;
   localparam int OPND_MSB = 7;

   localparam int FLAG_Z  = 0;
   localparam int FLAG_CY = 1;
   localparam int FLAG_OV = 2;
   localparam int FLAG_P  = 3;
   localparam int FLAG_S  = 4;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_NOT = 4'd1,
      OP_XOR = 4'd2,
      OP_OR  = 4'd3,
      OP_AND = 4'd4,
      OP_SUB = 4'd5,
      OP_ADD = 4'd6,
      OP_RR  = 4'd7,
      OP_RL  = 4'd8,
      OP_DEC = 4'd9,
      OP_INC = 4'd10,
      OP_LDI = 4'd11,
      OP_LDA = 4'd12,
      OP_STA = 4'd13,
      OP_JMP = 4'd14,
      OP_JZ  = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DECODE  = 2'd2,
      EXECUTE = 2'd3
   } state_e;

   // Opcodes 1..10 are computed by the ALU and write acc back.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd10);
   endfunction

endpackage

// File: rtl/seq_flag_reg.sv
// Flag register with per-opcode update mask:
// z/p/s on every ALU op, cy on ADD only, ov on ADD and SUB.
module seq_flag_reg
   import exec_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [3:0] opc_i,
   input  logic       z_i,
   input  logic       cy_i,
   input  logic       ov_i,
   input  logic       p_i,
   input  logic       s_i,
   output logic [4:0] flags_o
);

   logic [4:0] flags_q;
   logic [4:0] flags_d;

   // Merge live ALU flags into the held set according to the opcode.
   always_comb begin
      flags_d = flags_q;
      if (en_i && is_alu_op(opc_i)) begin
         flags_d[FLAG_Z] = z_i;
         flags_d[FLAG_P] = p_i;
         flags_d[FLAG_S] = s_i;
         if (opc_i == OP_ADD) begin
            flags_d[FLAG_CY] = cy_i;
         end
         if ((opc_i == OP_ADD) || (opc_i == OP_SUB)) begin
            flags_d[FLAG_OV] = ov_i;
         end
      end
   end

   // Flag state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_o = flags_q;

endmodule

// File: rtl/exec_sequencer.sv
// Three-cycle fetch/decode/execute control stage in front of the 8-bit ALU.
// Optional build macro SINGLE_STEP_EN adds a step input for single-stepping from IDLE.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int RF_AW = 3,
   parameter int IW    = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
`ifdef SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic             busy,
   output logic [PC_W-1:0]  pm_addr,
   output logic             pm_re,
   input  logic [IW-1:0]    pm_rdata,
   output logic [RF_AW-1:0] rf_addr,
   input  logic [7:0]       rf_rdata,
   output logic             rf_we,
   output logic [7:0]       rf_wdata,
   output logic [3:0]       alu_instr,
   output logic [7:0]       alu_acc,
   output logic [7:0]       alu_opnd,
   input  logic [7:0]       alu_result,
   input  logic             alu_z,
   input  logic             alu_cy,
   input  logic             alu_ov,
   input  logic             alu_p,
   input  logic             alu_s,
   output logic [7:0]       acc,
   output logic [4:0]       flags,
   output logic [PC_W-1:0]  pc
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [7:0]      acc_q, acc_d;

   logic [3:0]      opc;
   logic [7:0]      opnd;
   logic [PC_W-1:0] jmp_tgt;
   logic            is_exec;
   logic            go;
   logic [4:0]      flags_w;

   assign opc     = ir_q[OPC_MSB:OPC_LSB];
   assign opnd    = ir_q[OPND_MSB:0];
   assign jmp_tgt = PC_W'(opnd);
   assign is_exec = (state_q == EXECUTE);

`ifdef SINGLE_STEP_EN
   assign go = run | step;
`else
   assign go = run;
`endif

   // Next-state and datapath updates; writes land at the closing edge of EXECUTE.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      unique case (state_q)
         IDLE: begin
            if (go) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = DECODE;
         end
         DECODE: begin
            ir_d    = pm_rdata;
            pc_d    = pc_q + PC_W'(1);
            state_d = EXECUTE;
         end
         EXECUTE: begin
            state_d = run ? FETCH : IDLE;
            unique case (1'b1)
               is_alu_op(opc):    acc_d = alu_result;
               (opc == OP_LDI):   acc_d = opnd;
               (opc == OP_LDA):   acc_d = rf_rdata;
               (opc == OP_JMP):   pc_d  = jmp_tgt;
               (opc == OP_JZ): begin
                  if (flags_w[FLAG_Z]) begin
                     pc_d = jmp_tgt;
                  end
               end
               default: ;
            endcase
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Architectural state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
      end
   end

   seq_flag_reg u_flags (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (is_exec),
      .opc_i   (opc),
      .z_i     (alu_z),
      .cy_i    (alu_cy),
      .ov_i    (alu_ov),
      .p_i     (alu_p),
      .s_i     (alu_s),
      .flags_o (flags_w)
   );

   assign busy      = (state_q != IDLE);
   assign pm_addr   = pc_q;
   assign pm_re     = (state_q == FETCH);
   assign rf_addr   = ir_q[RF_AW-1:0];
   assign rf_we     = is_exec && (opc == OP_STA);
   assign rf_wdata  = acc_q;
   assign alu_instr = is_exec ? opc : OP_NOP;
   assign alu_acc   = acc_q;
   assign alu_opnd  = rf_rdata;
   assign acc       = acc_q;
   assign flags     = flags_w;
   assign pc        = pc_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with behavioural program memory,
// register file and ALU around it.
module tb_exec_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
`ifdef SINGLE_STEP_EN
   logic        step;
`endif
   logic        busy;
   logic [7:0]  pm_addr;
   logic        pm_re;
   logic [11:0] pm_rdata;
   logic [2:0]  rf_addr;
   logic [7:0]  rf_rdata;
   logic        rf_we;
   logic [7:0]  rf_wdata;
   logic [3:0]  alu_instr;
   logic [7:0]  alu_acc;
   logic [7:0]  alu_opnd;
   logic [7:0]  alu_result;
   logic        alu_z, alu_cy, alu_ov, alu_p, alu_s;
   logic [7:0]  acc;
   logic [4:0]  flags;
   logic [7:0]  pc;

   logic [11:0] pmem [256];
   logic [7:0]  rf [8];
   logic        tb_wr;
   logic [2:0]  tb_wa;
   logic [7:0]  tb_wd;
   logic [8:0]  r9;

   int n_chk;
   int n_fail;
   int cnt;

   exec_sequencer #(.PC_W(8), .RF_AW(3), .IW(12)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
`ifdef SINGLE_STEP_EN
      .step       (step),
`endif
      .busy       (busy),
      .pm_addr    (pm_addr),
      .pm_re      (pm_re),
      .pm_rdata   (pm_rdata),
      .rf_addr    (rf_addr),
      .rf_rdata   (rf_rdata),
      .rf_we      (rf_we),
      .rf_wdata   (rf_wdata),
      .alu_instr  (alu_instr),
      .alu_acc    (alu_acc),
      .alu_opnd   (alu_opnd),
      .alu_result (alu_result),
      .alu_z      (alu_z),
      .alu_cy     (alu_cy),
      .alu_ov     (alu_ov),
      .alu_p      (alu_p),
      .alu_s      (alu_s),
      .acc        (acc),
      .flags      (flags),
      .pc         (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pm_re) pm_rdata <= pmem[pm_addr];
   end

   always @(posedge clk) begin
      if (rf_we) rf[rf_addr] <= rf_wdata;
      else if (tb_wr) rf[tb_wa] <= tb_wd;
   end

   assign rf_rdata = rf[rf_addr];

   always_comb begin
      r9     = {1'b0, alu_acc};
      alu_ov = 1'b0;
      case (alu_instr)
         4'd1:  r9 = {1'b0, ~alu_acc};
         4'd2:  r9 = {1'b0, alu_acc ^ alu_opnd};
         4'd3:  r9 = {1'b0, alu_acc | alu_opnd};
         4'd4:  r9 = {1'b0, alu_acc & alu_opnd};
         4'd5: begin
            r9     = {1'b0, alu_acc} - {1'b0, alu_opnd};
            alu_ov = (alu_acc[7] != alu_opnd[7]) && (r9[7] != alu_acc[7]);
         end
         4'd6: begin
            r9     = {1'b0, alu_acc} + {1'b0, alu_opnd};
            alu_ov = (alu_acc[7] == alu_opnd[7]) && (r9[7] != alu_acc[7]);
         end
         4'd7:  r9 = {1'b0, alu_acc[0], alu_acc[7:1]};
         4'd8:  r9 = {1'b0, alu_acc[6:0], alu_acc[7]};
         4'd9:  r9 = {1'b0, alu_acc} - 9'd1;
         4'd10: r9 = {1'b0, alu_acc} + 9'd1;
         default: ;
      endcase
      alu_result = r9[7:0];
      alu_cy     = r9[8];
      alu_z      = (r9[7:0] == 8'h00);
      alu_p      = ~^r9[7:0];
      alu_s      = r9[7];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] ins(input logic [3:0] o,
                                       input logic [7:0] d);
      return {o, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rf_poke(input logic [2:0] a, input logic [7:0] d);
      tb_wa = a;
      tb_wd = d;
      tb_wr = 1'b1;
      tick();
      tb_wr = 1'b0;
   endtask

   task automatic clr_pmem();
      for (int i = 0; i < 256; i++) pmem[i] = 12'h000;
   endtask

   task automatic do_reset();
      run   = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Execute n instructions from IDLE and return to IDLE.
   task automatic exec_n(input int n);
      run = 1'b1;
      repeat (3 * n) @(posedge clk);
      #1 run = 1'b0;
      tick();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      run = 1'b0;
`ifdef SINGLE_STEP_EN
      step = 1'b0;
`endif
      tb_wr = 1'b0;
      tb_wa = '0;
      tb_wd = '0;
      clr_pmem();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) rf_poke(3'(i), 8'h00);
      rf_poke(3'd1, 8'h01);

      chk("rst_busy", busy, 0);
      chk("rst_pc", pc, 0);
      chk("rst_acc", acc, 0);
      chk("rst_flags", flags, 0);
      chk("rst_pm_re", pm_re, 0);
      chk("rst_alu_instr", alu_instr, 0);

      // Async reset while STA is executing.
      pmem[0] = ins(4'd11, 8'h05);
      pmem[1] = ins(4'd13, 8'h03);
      run = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("sta_we", rf_we, 1);
      chk("sta_wdata", rf_wdata, 8'h05);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_we", rf_we, 0);
      chk("arst_pc", pc, 0);
      chk("arst_acc", acc, 0);
      chk("arst_flags", flags, 0);
      chk("arst_busy", busy, 0);
      run = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_rf3", rf[3], 8'h00);

      // LDI FF; ADD r1 then LDI 5; STA r2; LDI 0; LDA r2.
      clr_pmem();
      pmem[0] = ins(4'd11, 8'hFF);
      pmem[1] = ins(4'd6, 8'h01);
      pmem[2] = ins(4'd11, 8'h05);
      pmem[3] = ins(4'd13, 8'h02);
      pmem[4] = ins(4'd11, 8'h00);
      pmem[5] = ins(4'd12, 8'h02);
      do_reset();
      run = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("add_busy", busy, 1);
      chk("add_instr", alu_instr, 4'd6);
      chk("add_alu_acc", alu_acc, 8'hFF);
      chk("add_alu_opnd", alu_opnd, 8'h01);
      chk("add_acc_pre", acc, 8'hFF);
      tick();
      chk("add_acc", acc, 8'h00);
      chk("add_flags", flags, 5'b01011);
      repeat (11) @(posedge clk);
      #1 run = 1'b0;
      tick();
      chk("lda_rf2", rf[2], 8'h05);
      chk("lda_acc", acc, 8'h05);
      chk("lda_flags", flags, 5'b01011);
      chk("lda_pc", pc, 8'h06);
      chk("lda_busy", busy, 0);

      // JZ taken, then not taken, then JMP to 0xFF and wrap.
      clr_pmem();
      rf_poke(3'd0, 8'h00);
      pmem[8'h00] = ins(4'd11, 8'h01);
      pmem[8'h01] = ins(4'd9, 8'h00);
      pmem[8'h02] = ins(4'd15, 8'h20);
      pmem[8'h20] = ins(4'd11, 8'h01);
      pmem[8'h21] = ins(4'd10, 8'h00);
      pmem[8'h22] = ins(4'd15, 8'h40);
      pmem[8'h23] = ins(4'd14, 8'hFF);
      pmem[8'hFF] = ins(4'd0, 8'h00);
      do_reset();
      exec_n(3);
      chk("jz_pc", pc, 8'h20);
      chk("jz_acc", acc, 8'h00);
      chk("jz_flags", flags, 5'b01001);
      run = 1'b1;
      tick();
      chk("jz_fetch_re", pm_re, 1);
      chk("jz_fetch_addr", pm_addr, 8'h20);
      repeat (8) @(posedge clk);
      #1 run = 1'b0;
      tick();
      chk("jnz_pc", pc, 8'h23);
      chk("jnz_acc", acc, 8'h02);
      chk("jnz_flags", flags, 5'b00000);
      exec_n(2);
      chk("wrap_pc", pc, 8'h00);
      chk("wrap_acc", acc, 8'h02);

      // Drop run during DECODE: the instruction still completes.
      run = 1'b1;
      tick();
      tick();
      run = 1'b0;
      chk("drop_dec_busy", busy, 1);
      tick();
      chk("drop_exec_instr", alu_instr, 4'd11);
      chk("drop_exec_busy", busy, 1);
      tick();
      chk("drop_idle_busy", busy, 0);
      chk("drop_acc", acc, 8'h01);
      chk("drop_pc", pc, 8'h01);
      tick();
      chk("drop_hold_re", pm_re, 0);
      chk("drop_hold_busy", busy, 0);

`ifdef SINGLE_STEP_EN
      clr_pmem();
      do_reset();
      step = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) step = 1'b0;
         cnt += int'(pm_re);
      end
      chk("step_one_re", cnt, 1);
      chk("step_one_busy", busy, 0);
      chk("step_one_pc", pc, 8'h01);
      step = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         cnt += int'(pm_re);
      end
      step = 1'b0;
      chk("step_held_re", cnt, 2);
      chk("step_held_busy", busy, 0);
      chk("step_held_pc", pc, 8'h03);
      tick();
      chk("step_idle_re", pm_re, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Fetch/decode/execute control stage that sits directly upstream of the 8-bit ALU and consumes its result.
- Owns the program counter, instruction register, accumulator and flag register.
- Sequences program-memory reads and register-file accesses.
- Presents opcode and operands to the ALU and writes its result and flags back.
- Every instruction takes three cycles.

Parameters:
PC_W, 8, program counter / program memory address width
RF_AW, 3, register-file address width; taken from operand[RF_AW-1:0]
IW, 12, instruction width; opcode = [11:8], operand = [7:0]

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; while high, instructions are fetched back to back
busy  out  1  high in any state other than IDLE
pm_addr  out  PC_W  program memory address
pm_re  out  1  program memory read strobe
pm_rdata  in  IW  instruction word, valid one cycle after pm_re
rf_addr  out  RF_AW  register-file address (combinational read)
rf_rdata  in  8  register-file read data
rf_we  out  1  register-file write enable
rf_wdata  out  8  register-file write data (always acc)
alu_instr  out  4  opcode to ALU
alu_acc  out  8  accumulator to ALU
alu_opnd  out  8  second ALU operand (rf_rdata)
alu_result  in  8  ALU result
alu_z, alu_cy, alu_ov, alu_p, alu_s  in  1 each  ALU flags
acc  out  8  accumulator
flags  out  5  {s,p,ov,cy,z} flag register
pc  out  PC_W  program counter

Behaviour:
- Reset (async, rst_n low), all outputs and registers return immediately:
  - state=IDLE; pc=0, ir=0, acc=0, flags=0.
  - pm_re=0, rf_we=0, busy=0, alu_instr=0.
- FSM states IDLE, FETCH, DECODE, EXECUTE:
  - IDLE: if run=1 → FETCH; otherwise hold.
  - FETCH: pm_addr=pc, pm_re=1 for this cycle only → DECODE.
  - DECODE: ir <= pm_rdata; pc <= pc+1 (wraps 2^PC_W-1 → 0) → EXECUTE.
  - EXECUTE: one cycle; alu_instr=ir[11:8]; rf_addr=ir[RF_AW-1:0]; all writes occur at the closing edge. Next state is FETCH if run=1, else IDLE.
- run is sampled only in IDLE and at the end of EXECUTE. Dropping run mid-instruction completes that instruction.
- Opcodes (shared package):
  - NOP=0, NOT=1, XOR=2, OR=3, AND=4, SUB=5, ADD=6, RR=7, RL=8, DEC=9, INC=10.
  - LDI=11: acc <= operand.
  - LDA=12: acc <= rf_rdata.
  - STA=13: rf_we=1 for the EXECUTE cycle; rf_wdata=acc.
  - JMP=14: pc <= operand[PC_W-1:0].
  - JZ=15: if flags.z=1, pc <= operand[PC_W-1:0]; otherwise no effect.
- ALU ops (1–10): acc <= alu_result at end of EXECUTE.
  - z, p, s are updated from the ALU on every ALU op.
  - cy is updated only on ADD; ov only on ADD and SUB. Both hold otherwise.
- LDI, LDA, STA, JMP, JZ and NOP leave flags unchanged.
- JZ tests the latched flag register, never the live ALU inputs.
- JMP/JZ overrides the pc+1 already applied in DECODE. JMP to the current address loops indefinitely; this is legal.
- alu_acc=acc and alu_opnd=rf_rdata are driven continuously. Outside EXECUTE, alu_instr=NOP.
- rf_we is asserted only in EXECUTE with STA, never in any other state.
- PC_W < 8: upper jump-operand bits are ignored.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input port step (1 bit).
  - In IDLE with run=0, a step=1 sample causes exactly one FETCH/DECODE/EXECUTE, then a return to IDLE.
  - step is ignored outside IDLE.
  - run=1 takes precedence over step.
- Undefined: no step port; IDLE is left only via run.

Decomposition:
- Shared package/include holds:
  - opcode constants;
  - field positions OPC_MSB=11, OPC_LSB=8, OPND_MSB=7;
  - state encoding IDLE=0, FETCH=1, DECODE=2, EXECUTE=3;
  - flag bit indices Z=0, CY=1, OV=2, P=3, S=4.
- One natural sub-module: seq_flag_reg, the per-opcode masked flag update register.

Test Plan:
- Reset mid-EXECUTE of STA → rf_we drops immediately; pc=0, acc=0, flags=0, busy=0.
- Program LDI 0xFF; ADD r1 (r1=0x01) → acc=0x00, flags.z=1, cy=1; 6 cycles from leaving IDLE to writeback.
- LDI 0x05; STA r2; LDI 0; LDA r2 → r2=0x05, acc=0x05, flags unchanged.
- LDI 1; DEC; JZ 0x20 → next pm_addr=0x20. Then LDI 1; INC; JZ 0x20 → not taken, pm_addr=pc+1.
- pc=0xFF holding NOP → next fetch pm_addr=0x00. Drop run during DECODE → instruction completes, then IDLE with busy=0.
- SINGLE_STEP_EN: run=0, one step pulse → exactly one pm_re pulse, then IDLE. step held high → one instruction per return to IDLE.
